// File: rtl/bp_cce_pkg.sv
// -----------------------------------------------------------------------------
// bp_cce_pkg
// Shared types for the CCE coherence directory:
//   - bp_cce_inst_minor_dir_op_e : directory command opcodes
//   - bp_coh_states_e            : per-entry coherence state
//   - bp_cce_dir_state_e         : directory controller FSM states
//   - DECLARE_BP_CCE_DIR_ENTRY_S : declares the {tag, state} entry struct for a
//                                  given tag width inside the using module
//   - BP_CCE_DIR_ROWS / BP_CCE_DIR_ENTRY_WIDTH : geometry helpers
// Optional feature macro used by the directory: BP_CCE_DIR_CLR_EN
// -----------------------------------------------------------------------------
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BP_CCE_DIR_ROWS
`define BP_CCE_DIR_ROWS(num_lce, lce_per_row) (((num_lce) + (lce_per_row) - 1) / (lce_per_row))
`endif

`ifndef BP_CCE_DIR_ENTRY_WIDTH
`define BP_CCE_DIR_ENTRY_WIDTH(tag_w) ((tag_w) + 2)
`endif

`ifndef DECLARE_BP_CCE_DIR_ENTRY_S
`define DECLARE_BP_CCE_DIR_ENTRY_S(tag_w) \
    typedef struct packed { \
        logic [(tag_w)-1:0] tag; \
        bp_coh_states_e     state; \
    } bp_cce_dir_entry_s
`endif

package bp_cce_pkg;

    typedef enum logic [1:0] {
        e_rdw_op = 2'd0,
        e_wde_op = 2'd1,
        e_wds_op = 2'd2,
        e_clr_op = 2'd3
    } bp_cce_inst_minor_dir_op_e;

    typedef enum logic [1:0] {
        e_COH_I = 2'd0,
        e_COH_S = 2'd1,
        e_COH_E = 2'd2,
        e_COH_M = 2'd3
    } bp_coh_states_e;

    typedef enum logic [1:0] {
        e_init  = 2'd0,
        e_ready = 2'd1,
        e_read  = 2'd2,
        e_clear = 2'd3
    } bp_cce_dir_state_e;

endpackage

// File: rtl/bp_cce_dir_tag_checker.sv
// -----------------------------------------------------------------------------
// bp_cce_dir_tag_checker
// Compares one directory row (lce_per_row_p LCEs x assoc_p ways) against a tag.
//   row_i    : packed row of {tag, state} entries, [lce slot][way]
//   slot_v_i : slot holds a real LCE (padding slots never hit)
//   tag_i    : tag to look up
//   hit_o    : per-slot hit (tag match and state != e_COH_I)
//   way_o    : lowest hitting way, 0 when no hit
//   state_o  : state of the lowest hitting way, e_COH_I when no hit
// -----------------------------------------------------------------------------
module bp_cce_dir_tag_checker
    import bp_cce_pkg::*;
#(
    parameter int assoc_p       = 8,
    parameter int lce_per_row_p = 2,
    parameter int tag_width_p   = 28,
    localparam int lg_assoc_lp  = `BSG_SAFE_CLOG2(assoc_p),
    localparam int row_width_lp = lce_per_row_p * assoc_p * `BP_CCE_DIR_ENTRY_WIDTH(tag_width_p)
) (
    input  logic [row_width_lp-1:0]                     row_i,
    input  logic [lce_per_row_p-1:0]                    slot_v_i,
    input  logic [tag_width_p-1:0]                      tag_i,
    output logic [lce_per_row_p-1:0]                    hit_o,
    output logic [lce_per_row_p-1:0][lg_assoc_lp-1:0]   way_o,
    output bp_coh_states_e [lce_per_row_p-1:0]          state_o
);

    `DECLARE_BP_CCE_DIR_ENTRY_S(tag_width_p);

    bp_cce_dir_entry_s [lce_per_row_p-1:0][assoc_p-1:0] row;
    assign row = row_i;

    // Scan ways from high to low so the lowest matching way wins.
    always_comb begin
        hit_o   = '0;
        way_o   = '0;
        for (int s = 0; s < lce_per_row_p; s++) begin
            state_o[s] = e_COH_I;
            for (int w = assoc_p - 1; w >= 0; w--) begin
                if (slot_v_i[s] && (row[s][w].tag == tag_i) && (row[s][w].state != e_COH_I)) begin
                    hit_o[s]   = 1'b1;
                    way_o[s]   = lg_assoc_lp'(w);
                    state_o[s] = row[s][w].state;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit.sv
// -----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_bit
// Single-port synchronous RAM with per-bit write mask.
//   clk_i    : clock
//   v_i      : access enable; w_i selects write (1) or read (0)
//   addr_i   : row address
//   data_i   : write data, w_mask_i : per-bit write enable
//   data_o   : read data, valid the cycle after a read access, held otherwise
// -----------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_bit #(
    parameter int width_p = 1,
    parameter int els_p   = 1,
    localparam int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       w_mask_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                mem_r[addr_i] <= (mem_r[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
            end else begin
                data_o <= mem_r[addr_i];
            end
        end
    end

endmodule

// File: rtl/bp_cce_dir_rowed.sv
// -----------------------------------------------------------------------------
// bp_cce_dir_rowed
// Coherence directory storing lce_per_row_p LCEs per memory row.
//   clk_i, reset_n_i       : clock, asynchronous active-low reset
//   v_i / ready_o          : command handshake (accepted when both high)
//   cmd_i                  : e_rdw_op read, e_wde_op write entry, e_wds_op write
//                            state, e_clr_op clear set
//   set_i, tag_i, lce_i, way_i, lru_way_i, coh_state_i : command operands
//   sharers_v_o            : one-cycle pulse when a read completes
//   sharers_hits_o/ways_o/coh_states_o : per-LCE lookup result (held)
//   lru_v_o, lru_cached_excl_o, lru_tag_o : entry (lce_i, lru_way_i) of the read
// Optional feature: define BP_CCE_DIR_CLR_EN to make e_clr_op invalidate every
// entry of set_i; otherwise e_clr_op is accepted and ignored.
// -----------------------------------------------------------------------------
module bp_cce_dir_rowed
    import bp_cce_pkg::*;
#(
    parameter int sets_p        = 64,
    parameter int assoc_p       = 8,
    parameter int num_lce_p     = 8,
    parameter int lce_per_row_p = 2,
    parameter int tag_width_p   = 28,
    localparam int rows_lp       = `BP_CCE_DIR_ROWS(num_lce_p, lce_per_row_p),
    localparam int lg_sets_lp    = `BSG_SAFE_CLOG2(sets_p),
    localparam int lg_num_lce_lp = `BSG_SAFE_CLOG2(num_lce_p),
    localparam int lg_assoc_lp   = `BSG_SAFE_CLOG2(assoc_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  v_i,
    output logic                                  ready_o,
    input  bp_cce_inst_minor_dir_op_e             cmd_i,
    input  logic [lg_sets_lp-1:0]                 set_i,
    input  logic [tag_width_p-1:0]                tag_i,
    input  logic [lg_num_lce_lp-1:0]              lce_i,
    input  logic [lg_assoc_lp-1:0]                way_i,
    input  logic [lg_assoc_lp-1:0]                lru_way_i,
    input  bp_coh_states_e                        coh_state_i,
    output logic                                  sharers_v_o,
    output logic [num_lce_p-1:0]                  sharers_hits_o,
    output logic [num_lce_p-1:0][lg_assoc_lp-1:0] sharers_ways_o,
    output bp_coh_states_e [num_lce_p-1:0]        sharers_coh_states_o,
    output logic                                  lru_v_o,
    output logic                                  lru_cached_excl_o,
    output logic [tag_width_p-1:0]                lru_tag_o
);

    `DECLARE_BP_CCE_DIR_ENTRY_S(tag_width_p);

    localparam int entry_w_lp   = `BP_CCE_DIR_ENTRY_WIDTH(tag_width_p);
    localparam int row_width_lp = lce_per_row_p * assoc_p * entry_w_lp;
    localparam int mem_els_lp   = sets_p * rows_lp;
    localparam int lg_mem_lp    = `BSG_SAFE_CLOG2(mem_els_lp);
    localparam int lg_rows_lp   = `BSG_SAFE_CLOG2(rows_lp);
    localparam int lg_slot_lp   = `BSG_SAFE_CLOG2(lce_per_row_p);

    localparam logic [lg_rows_lp-1:0] last_row_lp  = lg_rows_lp'(rows_lp - 1);
    localparam logic [lg_mem_lp-1:0]  last_addr_lp = lg_mem_lp'(mem_els_lp - 1);
    localparam logic [entry_w_lp-1:0] state_mask_lp =
        {{tag_width_p{1'b0}}, {$bits(bp_coh_states_e){1'b1}}};

    // Control state
    bp_cce_dir_state_e                 state_q;
    logic [lg_mem_lp-1:0]              init_addr_q;
    logic [lg_rows_lp-1:0]             row_cnt_q;
    logic                              ready_q;
    logic                              sharers_v_q;
    logic                              lru_v_q;
    logic                              lru_excl_q;
    logic [tag_width_p-1:0]            lru_tag_q;
    logic [num_lce_p-1:0]              hits_q;
    logic [num_lce_p-1:0][lg_assoc_lp-1:0] ways_q;
    bp_coh_states_e [num_lce_p-1:0]    states_q;

    // Operands captured at acceptance
    logic [lg_sets_lp-1:0]             set_q;
    logic [tag_width_p-1:0]            tag_q;
    logic [lg_num_lce_lp-1:0]          lce_q;
    logic [lg_assoc_lp-1:0]            lru_way_q;

    // Memory port
    logic                              mem_v, mem_w;
    logic [lg_mem_lp-1:0]              mem_addr;
    logic [lce_per_row_p-1:0][assoc_p-1:0][entry_w_lp-1:0] mem_wdata_arr, mem_mask_arr;
    logic [row_width_lp-1:0]           mem_rdata;
    bp_cce_dir_entry_s [lce_per_row_p-1:0][assoc_p-1:0] rd_arr;

    // Tag checker results for the row currently on mem_rdata
    logic [lce_per_row_p-1:0]                  slot_v;
    logic [lce_per_row_p-1:0]                  chk_hit;
    logic [lce_per_row_p-1:0][lg_assoc_lp-1:0] chk_way;
    bp_coh_states_e [lce_per_row_p-1:0]        chk_state;

    logic                     accept, set_ok, lce_ok, acc_rd, acc_wr;
    logic                     lru_row_match;
    logic [lg_slot_lp-1:0]    lru_slot;
    bp_cce_dir_entry_s        lru_entry;

    function automatic logic [lg_mem_lp-1:0] row_addr(input logic [lg_sets_lp-1:0] s, input int r);
        return lg_mem_lp'(int'(s) * rows_lp + r);
    endfunction

    assign accept = v_i & ready_q;
    assign set_ok = int'(set_i) < sets_p;
    assign lce_ok = int'(lce_i) < num_lce_p;
    assign acc_rd = accept && (cmd_i == e_rdw_op) && set_ok;
    assign acc_wr = accept && ((cmd_i == e_wde_op) || (cmd_i == e_wds_op)) && set_ok && lce_ok;
`ifdef BP_CCE_DIR_CLR_EN
    logic acc_clr;
    assign acc_clr = accept && (cmd_i == e_clr_op) && set_ok;
`endif

    always_ff @(posedge clk_i) begin
        if (accept) begin
            set_q     <= set_i;
            tag_q     <= tag_i;
            lce_q     <= lce_i;
            lru_way_q <= lru_way_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && accept) begin
            assert (set_ok && (lce_ok || (cmd_i == e_rdw_op) || (cmd_i == e_clr_op)))
                else $error("bp_cce_dir_rowed: out-of-range set/lce command ignored");
        end
    end

    // Memory request: init sweep, read issue, masked writes, clear sweep.
    always_comb begin
        mem_v         = 1'b0;
        mem_w         = 1'b0;
        mem_addr      = '0;
        mem_wdata_arr = '0;
        mem_mask_arr  = '0;
        case (state_q)
            e_init: begin
                mem_v        = 1'b1;
                mem_w        = 1'b1;
                mem_addr     = init_addr_q;
                mem_mask_arr = '1;
            end
            e_ready: begin
                if (acc_rd) begin
                    mem_v    = 1'b1;
                    mem_addr = row_addr(set_i, 0);
                end else if (acc_wr) begin
                    mem_v    = 1'b1;
                    mem_w    = 1'b1;
                    mem_addr = row_addr(set_i, int'(lce_i) / lce_per_row_p);
                    for (int s = 0; s < lce_per_row_p; s++) begin
                        for (int w = 0; w < assoc_p; w++) begin
                            if ((s == int'(lce_i) % lce_per_row_p) && (w == int'(way_i))) begin
                                mem_wdata_arr[s][w] = {tag_i, coh_state_i};
                                mem_mask_arr[s][w]  = (cmd_i == e_wde_op) ? '1 : state_mask_lp;
                            end
                        end
                    end
                end
            end
            e_read: begin
                // Prefetch the next row while the current one is being checked.
                if (row_cnt_q != last_row_lp) begin
                    mem_v    = 1'b1;
                    mem_addr = row_addr(set_q, int'(row_cnt_q) + 1);
                end
            end
`ifdef BP_CCE_DIR_CLR_EN
            e_clear: begin
                // Invalidate only: states go to e_COH_I, tags are kept.
                mem_v    = 1'b1;
                mem_w    = 1'b1;
                mem_addr = row_addr(set_q, int'(row_cnt_q));
                for (int s = 0; s < lce_per_row_p; s++) begin
                    for (int w = 0; w < assoc_p; w++) begin
                        mem_mask_arr[s][w] = state_mask_lp;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    bsg_mem_1rw_sync_mask_write_bit #(
        .width_p (row_width_lp),
        .els_p   (mem_els_lp)
    ) dir_mem (
        .clk_i    (clk_i),
        .data_i   (mem_wdata_arr),
        .addr_i   (mem_addr),
        .v_i      (mem_v),
        .w_mask_i (mem_mask_arr),
        .w_i      (mem_w),
        .data_o   (mem_rdata)
    );

    // Padding slots in the last row map to LCE ids >= num_lce_p.
    always_comb begin
        for (int s = 0; s < lce_per_row_p; s++) begin
            slot_v[s] = (int'(row_cnt_q) * lce_per_row_p + s) < num_lce_p;
        end
    end

    bp_cce_dir_tag_checker #(
        .assoc_p       (assoc_p),
        .lce_per_row_p (lce_per_row_p),
        .tag_width_p   (tag_width_p)
    ) tag_checker (
        .row_i    (mem_rdata),
        .slot_v_i (slot_v),
        .tag_i    (tag_q),
        .hit_o    (chk_hit),
        .way_o    (chk_way),
        .state_o  (chk_state)
    );

    assign rd_arr        = mem_rdata;
    assign lru_row_match = (int'(lce_q) / lce_per_row_p) == int'(row_cnt_q);
    assign lru_slot      = lg_slot_lp'(int'(lce_q) % lce_per_row_p);
    assign lru_entry     = rd_arr[lru_slot][lru_way_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_init;
            init_addr_q <= '0;
            row_cnt_q   <= '0;
            ready_q     <= 1'b0;
            sharers_v_q <= 1'b0;
            lru_v_q     <= 1'b0;
            lru_excl_q  <= 1'b0;
            lru_tag_q   <= '0;
            hits_q      <= '0;
            ways_q      <= '0;
            for (int l = 0; l < num_lce_p; l++) states_q[l] <= e_COH_I;
        end else begin
            sharers_v_q <= 1'b0;
            lru_v_q     <= 1'b0;
            case (state_q)
                e_init: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == last_addr_lp) begin
                        state_q <= e_ready;
                        ready_q <= 1'b1;
                    end
                end
                e_ready: begin
                    if (acc_rd) begin
                        state_q   <= e_read;
                        ready_q   <= 1'b0;
                        row_cnt_q <= '0;
                    end
`ifdef BP_CCE_DIR_CLR_EN
                    else if (acc_clr) begin
                        state_q   <= e_clear;
                        ready_q   <= 1'b0;
                        row_cnt_q <= '0;
                    end
`endif
                end
                e_read: begin
                    for (int l = 0; l < num_lce_p; l++) begin
                        if ((l / lce_per_row_p) == int'(row_cnt_q)) begin
                            hits_q[l]   <= chk_hit[l % lce_per_row_p];
                            ways_q[l]   <= chk_way[l % lce_per_row_p];
                            states_q[l] <= chk_state[l % lce_per_row_p];
                        end
                    end
                    if (lru_row_match) begin
                        lru_tag_q  <= lru_entry.tag;
                        lru_excl_q <= (lru_entry.state == e_COH_M) || (lru_entry.state == e_COH_E);
                    end
                    if (row_cnt_q == last_row_lp) begin
                        state_q     <= e_ready;
                        ready_q     <= 1'b1;
                        sharers_v_q <= 1'b1;
                        lru_v_q     <= 1'b1;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end
`ifdef BP_CCE_DIR_CLR_EN
                e_clear: begin
                    if (row_cnt_q == last_row_lp) begin
                        state_q <= e_ready;
                        ready_q <= 1'b1;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= e_ready;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o              = ready_q;
    assign sharers_v_o          = sharers_v_q;
    assign sharers_hits_o       = hits_q;
    assign sharers_ways_o       = ways_q;
    assign sharers_coh_states_o = states_q;
    assign lru_v_o              = lru_v_q;
    assign lru_cached_excl_o    = lru_excl_q;
    assign lru_tag_o            = lru_tag_q;

endmodule

// File: tb/tb_bp_cce_dir_rowed.sv
`timescale 1ns/1ps
module tb_bp_cce_dir_rowed;
    import bp_cce_pkg::*;

    localparam int SETS = 4, ASSOC = 2, NLCE = 4, PER_ROW = 2, TAGW = 28, ROWS = 2;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b1;
    logic                         v = 1'b0;
    logic                         ready;
    bp_cce_inst_minor_dir_op_e    cmd = e_rdw_op;
    logic [1:0]                   set = '0;
    logic [TAGW-1:0]              tag = '0;
    logic [1:0]                   lce = '0;
    logic [0:0]                   way = '0, lru_way = '0;
    bp_coh_states_e               coh = e_COH_I;
    logic                         sharers_v;
    logic [NLCE-1:0]              hits;
    logic [NLCE-1:0][0:0]         ways;
    bp_coh_states_e [NLCE-1:0]    states;
    logic                         lru_v, lru_excl;
    logic [TAGW-1:0]              lru_tag;

    always #5 clk = ~clk;

    bp_cce_dir_rowed #(
        .sets_p(SETS), .assoc_p(ASSOC), .num_lce_p(NLCE),
        .lce_per_row_p(PER_ROW), .tag_width_p(TAGW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready), .cmd_i(cmd),
        .set_i(set), .tag_i(tag), .lce_i(lce), .way_i(way), .lru_way_i(lru_way),
        .coh_state_i(coh), .sharers_v_o(sharers_v), .sharers_hits_o(hits),
        .sharers_ways_o(ways), .sharers_coh_states_o(states), .lru_v_o(lru_v),
        .lru_cached_excl_o(lru_excl), .lru_tag_o(lru_tag)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference directory: plain arrays indexed by set / lce / way.
    logic [TAGW-1:0] m_tag [SETS][NLCE][ASSOC];
    bp_coh_states_e  m_st  [SETS][NLCE][ASSOC];
    logic [NLCE-1:0] last_hits;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int l = 0; l < NLCE; l++)
                for (int w = 0; w < ASSOC; w++) begin
                    m_tag[s][l][w] = '0;
                    m_st[s][l][w]  = e_COH_I;
                end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command when ready; returns one sample after the accepting edge.
    task automatic issue(input bp_cce_inst_minor_dir_op_e op, input int s, input logic [TAGW-1:0] t,
                         input int l, input int w, input int lw, input bp_coh_states_e c);
        int g = 0;
        while (!ready && g < 50) begin step(); g++; end
        if (!ready) check("ready_wait", 64'(ready), 64'd1);
        cmd = op; set = 2'(s); tag = t; lce = 2'(l); way = 1'(w); lru_way = 1'(lw); coh = c;
        v = 1'b1;
        step();
        v = 1'b0;
        case (op)
            e_wde_op: begin m_tag[s][l][w] = t; m_st[s][l][w] = c; end
            e_wds_op: m_st[s][l][w] = c;
`ifdef BP_CCE_DIR_CLR_EN
            e_clr_op: for (int i = 0; i < NLCE; i++) for (int j = 0; j < ASSOC; j++) m_st[s][i][j] = e_COH_I;
`endif
            default: ;
        endcase
    endtask

    task automatic do_read(input int s, input logic [TAGW-1:0] t, input int l, input int lw, input bit chk_pulse);
        logic [NLCE-1:0]      eh;
        logic [NLCE-1:0][0:0] ew;
        logic [2*NLCE-1:0]    es;
        logic [TAGW-1:0]      elt;
        logic                 ex;
        int cyc;
        eh = '0; ew = '0; es = '0;
        for (int i = 0; i < NLCE; i++)
            for (int w = 0; w < ASSOC; w++)
                if (!eh[i] && m_tag[s][i][w] == t && m_st[s][i][w] != e_COH_I) begin
                    eh[i] = 1'b1; ew[i] = 1'(w); es[2*i +: 2] = m_st[s][i][w];
                end
        elt = m_tag[s][l][lw];
        ex  = (m_st[s][l][lw] == e_COH_M) || (m_st[s][l][lw] == e_COH_E);
        issue(e_rdw_op, s, t, l, 0, lw, e_COH_I);
        cyc = 1;
        while (!sharers_v && cyc < 10) begin step(); cyc++; end
        check("rd_latency", 64'(cyc), 64'(ROWS + 1));
        if (sharers_v) begin
            check("rd_hits", 64'(hits), 64'(eh));
            check("rd_ways", 64'(ways), 64'(ew));
            check("rd_states", 64'(states), 64'(es));
            check("rd_lru_v", 64'(lru_v), 64'd1);
            check("rd_lru_tag", 64'(lru_tag), 64'(elt));
            check("rd_lru_excl", 64'(lru_excl), 64'(ex));
            check("rd_ready_at_pulse", 64'(ready), 64'd1);
            last_hits = hits;
            if (chk_pulse) begin
                step();
                check("rd_pulse_width", 64'({sharers_v, lru_v}), 64'd0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        model_reset();
        last_hits = '0;
        #2 reset_n = 1'b0;
        step(); step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_outs", 64'({sharers_v, lru_v, lru_excl}), 64'd0);
        check("rst_lru_tag", 64'(lru_tag), 64'd0);
        check("rst_sharers", 64'({hits, ways, states}), 64'd0);
        reset_n = 1'b1;
        n = 0;
        while (!ready && n < 50) begin step(); n++; end
        check("init_cycles", 64'(n), 64'(SETS * ROWS));

        // Empty directory, then single writes and reads
        do_read(0, 28'h5, 0, 0, 1);
        check("empty_hits", 64'(last_hits), 64'h0);
        issue(e_wde_op, 1, 28'h12, 3, 1, 0, e_COH_M);
        do_read(1, 28'h12, 3, 1, 1);
        check("wde_hits", 64'(last_hits), 64'h8);
        check("wde_way3", 64'(ways[3]), 64'd1);
        check("wde_excl", 64'(lru_excl), 64'd1);
        check("wde_lru_tag", 64'(lru_tag), 64'h12);
        issue(e_wds_op, 1, 28'h0, 3, 1, 0, e_COH_I);
        do_read(1, 28'h12, 3, 1, 1);
        check("wds_hits", 64'(last_hits), 64'h0);
        check("wds_excl", 64'(lru_excl), 64'd0);
        check("wds_lru_tag", 64'(lru_tag), 64'h12);

        // Masked writes sharing rows with other LCEs
        issue(e_wde_op, 2, 28'h9, 1, 1, 0, e_COH_E);
        issue(e_wde_op, 2, 28'h7, 0, 0, 0, e_COH_S);
        issue(e_wde_op, 2, 28'h7, 2, 0, 0, e_COH_S);
        do_read(2, 28'h7, 0, 0, 1);
        check("mask_hits", 64'(last_hits), 64'h5);
        do_read(2, 28'h9, 1, 1, 1);
        check("mask_neighbor", 64'(last_hits), 64'h2);

        // Reset in the middle of a read
        issue(e_rdw_op, 1, 28'h12, 3, 0, 1, e_COH_I);
        reset_n = 1'b0;
        #1;
        check("midrd_rst_v", 64'({sharers_v, lru_v, ready}), 64'd0);
        model_reset();
        step(); step();
        reset_n = 1'b1;
        n = 0; seen = 0;
        while (!ready && n < 50) begin step(); n++; seen |= sharers_v; end
        check("midrd_reinit", 64'(n), 64'(SETS * ROWS));
        check("midrd_no_pulse", 64'(seen), 64'd0);
        do_read(2, 28'h7, 0, 0, 1);
        check("midrd_cleared", 64'(last_hits), 64'h0);

        // Set clear
        issue(e_wde_op, 2, 28'h7, 0, 0, 0, e_COH_S);
        issue(e_wde_op, 2, 28'h7, 2, 0, 0, e_COH_S);
        issue(e_clr_op, 2, 28'h0, 0, 0, 0, e_COH_I);
        n = 0; seen = 0;
        while (!ready && n < 10) begin n++; seen |= sharers_v; step(); end
`ifdef BP_CCE_DIR_CLR_EN
        check("clr_busy", 64'(n), 64'(ROWS));
`else
        check("clr_busy", 64'(n), 64'd0);
`endif
        check("clr_no_pulse", 64'(seen), 64'd0);
        do_read(2, 28'h7, 0, 0, 1);
`ifdef BP_CCE_DIR_CLR_EN
        check("clr_hits", 64'(last_hits), 64'h0);
`else
        check("clr_hits", 64'(last_hits), 64'h5);
`endif

        // Random traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            int r, s, l, w, lw;
            logic [TAGW-1:0] t;
            bp_coh_states_e c;
            r  = $urandom_range(0, 9);
            s  = $urandom_range(0, SETS - 1);
            l  = $urandom_range(0, NLCE - 1);
            w  = $urandom_range(0, ASSOC - 1);
            lw = $urandom_range(0, ASSOC - 1);
            t  = 28'($urandom_range(1, 3));
            c  = bp_coh_states_e'($urandom_range(0, 3));
            if (r < 4)       issue(e_wde_op, s, t, l, w, 0, c);
            else if (r < 6)  issue(e_wds_op, s, t, l, w, 0, c);
            else if (r < 9)  do_read(s, t, l, lw, bit'($urandom_range(0, 1)));
            else             issue(e_clr_op, s, t, l, w, 0, c);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
